// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the seven-segment scanner.
// Segment patterns are active-high, ordered {a,b,c,d,e,f,g}.
package seven_seg_pkg;

    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_B = 7'b0011111;
    localparam logic [6:0] SEG_C = 7'b1001110;
    localparam logic [6:0] SEG_D = 7'b0111101;
    localparam logic [6:0] SEG_E = 7'b1001111;
    localparam logic [6:0] SEG_F = 7'b1000111;

    localparam logic [6:0] SEG_ERR   = 7'b1001111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Counter width that never collapses to zero bits for n == 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to segment decoder, hex or decimal-with-error.
// Output is active-high; polarity is applied by the scanner.
module seg7_hex_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dec_mode,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        unique case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
        if (dec_mode && nibble > 4'd9) begin
            seg = SEG_ERR;
        end
    end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed N-digit seven-segment driver with a double-buffered value.
// Shadow commits to the display only at the frame boundary to avoid tearing.
module seven_segment_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter bit ACTIVE_LOW  = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    lz_en,
    input  logic                    dec_mode,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    pending,
    output logic                    frame_tick
);

    localparam int DW    = 4 * NUM_DIGITS;
    localparam int DIV_W = cnt_width(REFRESH_DIV);
    localparam int IDX_W = cnt_width(NUM_DIGITS);

    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;
    logic [DW-1:0]         shadow_q, shadow_d;
    logic [DW-1:0]         display_q, display_d;
    logic                  pending_q, pending_d;
    logic                  frame_tick_q, frame_tick_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;

    logic                  advance;
    logic                  boundary;
    logic [3:0]            nibble;
    logic                  upper_zero;
    logic                  blank_bit;
    logic [NUM_DIGITS-1:0] onehot;
    logic                  dark;
    logic [6:0]            dec_seg;

    assign advance  = (div_cnt_q == DIV_W'(REFRESH_DIV - 1));
    assign boundary = advance
                   && (digit_idx_q == IDX_W'(NUM_DIGITS - 1));

    // Select the scanned nibble and its blanking context.
    always_comb begin
        nibble     = 4'h0;
        upper_zero = 1'b0;
        blank_bit  = 1'b0;
        onehot     = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (digit_idx_q == IDX_W'(k)) begin
                nibble     = display_q[4*k +: 4];
                upper_zero = ((display_q >> (4*k)) == '0) && (k > 0);
                blank_bit  = blank_mask[k];
                onehot[k]  = 1'b1;
            end
        end
    end

    seg7_hex_decode u_dec (
        .nibble   (nibble),
        .dec_mode (dec_mode),
        .seg      (dec_seg)
    );

    assign dark = blank_bit || (lz_en && upper_zero);

    always_comb begin
        div_cnt_d    = div_cnt_q + DIV_W'(1);
        digit_idx_d  = digit_idx_q;
        shadow_d     = shadow_q;
        display_d    = display_q;
        pending_d    = pending_q;
        frame_tick_d = boundary;
        seg_d        = dark ? SEG_BLANK : dec_seg;
        dig_en_d     = dark ? '0 : onehot;

        if (advance) begin
            div_cnt_d   = '0;
            digit_idx_d = boundary ? '0 : digit_idx_q + IDX_W'(1);
        end

        // A load coinciding with the boundary bypasses the shadow.
        if (boundary) begin
            display_d = load ? data_in : shadow_q;
            if (load) begin
                shadow_d = data_in;
            end
            pending_d = 1'b0;
        end else if (load) begin
            shadow_d  = data_in;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q    <= '0;
            digit_idx_q  <= '0;
            shadow_q     <= '0;
            display_q    <= '0;
            pending_q    <= 1'b0;
            frame_tick_q <= 1'b0;
            seg_q        <= SEG_BLANK;
            dig_en_q     <= '0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            digit_idx_q  <= digit_idx_d;
            shadow_q     <= shadow_d;
            display_q    <= display_d;
            pending_q    <= pending_d;
            frame_tick_q <= frame_tick_d;
            seg_q        <= seg_d;
            dig_en_q     <= dig_en_d;
        end
    end

    assign seg        = ACTIVE_LOW ? ~seg_q : seg_q;
    assign dig_en     = ACTIVE_LOW ? ~dig_en_q : dig_en_q;
    assign pending    = pending_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner, 4 digits, 4 cycles per digit.
// A second instance covers the inverted-polarity build.
module tb_seven_segment_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] data_in;
    logic        load;
    logic [3:0]  blank_mask;
    logic        lz_en;
    logic        dec_mode;
    logic [6:0]  seg;
    logic [3:0]  dig_en;
    logic        pending;
    logic        frame_tick;

    logic        rst_al;
    logic [15:0] data_al;
    logic        load_al;
    logic [6:0]  seg_al;
    logic [3:0]  dig_al;
    logic        pend_al;
    logic        ft_al;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seven_segment_scanner #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4),
        .ACTIVE_LOW  (1'b0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .load       (load),
        .blank_mask (blank_mask),
        .lz_en      (lz_en),
        .dec_mode   (dec_mode),
        .seg        (seg),
        .dig_en     (dig_en),
        .pending    (pending),
        .frame_tick (frame_tick)
    );

    seven_segment_scanner #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4),
        .ACTIVE_LOW  (1'b1)
    ) dut_al (
        .clk        (clk),
        .reset      (rst_al),
        .data_in    (data_al),
        .load       (load_al),
        .blank_mask (4'b0000),
        .lz_en      (1'b0),
        .dec_mode   (1'b0),
        .seg        (seg_al),
        .dig_en     (dig_al),
        .pending    (pend_al),
        .frame_tick (ft_al)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    // Checks one full 16-cycle frame; call when the next edge starts digit 0.
    task automatic frame(input string tag,
                         input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3,
                         input logic [3:0] lit);
        logic [6:0] sv [4];
        logic [3:0] ed;
        int d;
        sv[0] = s0; sv[1] = s1; sv[2] = s2; sv[3] = s3;
        for (int c = 0; c < 16; c++) begin
            tick();
            d  = c / 4;
            ed = lit[d] ? (4'b0001 << d) : 4'b0000;
            chk($sformatf("%s seg c%0d", tag, c), {25'd0, seg}, {25'd0, sv[d]});
            chk($sformatf("%s dig c%0d", tag, c), {28'd0, dig_en}, {28'd0, ed});
            chk($sformatf("%s tick c%0d", tag, c), {31'd0, frame_tick},
                {31'd0, (c == 15)});
        end
    endtask

    initial begin
        reset      = 1'b1;
        data_in    = 16'h0000;
        load       = 1'b0;
        blank_mask = 4'b0000;
        lz_en      = 1'b0;
        dec_mode   = 1'b0;
        rst_al     = 1'b1;
        data_al    = 16'h0008;
        load_al    = 1'b0;

        ticks(3);
        chk("rst seg", {25'd0, seg}, 32'h0);
        chk("rst dig", {28'd0, dig_en}, 32'h0);
        chk("rst pend", {31'd0, pending}, 32'h0);
        chk("rst tick", {31'd0, frame_tick}, 32'h0);
        chk("al rst seg", {25'd0, seg_al}, 32'h7f);
        chk("al rst dig", {28'd0, dig_al}, 32'hf);

        reset   = 1'b0;
        rst_al  = 1'b0;
        load_al = 1'b1;

        frame("t1", 7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110, 4'hf);

        tick();
        chk("al seg d0", {25'd0, seg_al}, 32'h00);
        chk("al dig d0", {28'd0, dig_al}, 32'he);

        ticks(4);
        data_in = 16'h12AF;
        load    = 1'b1;
        tick();
        load = 1'b0;
        chk("t2 pend set", {31'd0, pending}, 32'h1);
        chk("t2 old seg", {25'd0, seg}, {25'd0, 7'b1111110});
        chk("t2 old dig", {28'd0, dig_en}, 32'h2);
        ticks(9);
        chk("t2 pend hold", {31'd0, pending}, 32'h1);
        tick();
        chk("t2 pend clr", {31'd0, pending}, 32'h0);
        chk("t2 bnd tick", {31'd0, frame_tick}, 32'h1);

        frame("t2", 7'b1000111, 7'b1110111, 7'b1101101, 7'b0110000, 4'hf);

        dec_mode = 1'b1;
        frame("t3a", 7'b1001111, 7'b1001111, 7'b1101101, 7'b0110000, 4'hf);

        ticks(15);
        chk("t3 pend pre", {31'd0, pending}, 32'h0);
        data_in = 16'h0003;
        load    = 1'b1;
        tick();
        load = 1'b0;
        chk("t3 pend bnd", {31'd0, pending}, 32'h0);
        chk("t3 bnd tick", {31'd0, frame_tick}, 32'h1);
        frame("t3b", 7'b1111001, 7'b1111110, 7'b1111110, 7'b1111110, 4'hf);
        chk("t3 pend post", {31'd0, pending}, 32'h0);

        lz_en    = 1'b1;
        dec_mode = 1'b0;
        data_in  = 16'h0005;
        load     = 1'b1;
        tick();
        load = 1'b0;
        chk("t4 pend", {31'd0, pending}, 32'h1);
        ticks(8);
        chk("t4 lz seg", {25'd0, seg}, 32'h0);
        chk("t4 lz dig", {28'd0, dig_en}, 32'h0);
        ticks(7);
        chk("t4 pend clr", {31'd0, pending}, 32'h0);
        frame("t4a", 7'b1011011, 7'b0000000, 7'b0000000, 7'b0000000, 4'b0001);

        data_in = 16'h0000;
        load    = 1'b1;
        tick();
        load = 1'b0;
        ticks(15);
        frame("t4b", 7'b1111110, 7'b0000000, 7'b0000000, 7'b0000000, 4'b0001);

        blank_mask = 4'b0001;
        frame("t4c", 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 4'b0000);

        blank_mask = 4'b0000;
        lz_en      = 1'b0;
        data_in    = 16'hFFFF;
        load       = 1'b1;
        tick();
        load = 1'b0;
        chk("t6 pend", {31'd0, pending}, 32'h1);
        ticks(2);
        reset = 1'b1;
        tick();
        chk("t6 rst pend", {31'd0, pending}, 32'h0);
        chk("t6 rst seg", {25'd0, seg}, 32'h0);
        chk("t6 rst dig", {28'd0, dig_en}, 32'h0);
        chk("t6 rst tick", {31'd0, frame_tick}, 32'h0);
        tick();
        reset = 1'b0;
        frame("t6a", 7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110, 4'hf);
        frame("t6b", 7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110, 4'hf);
        chk("t6 pend end", {31'd0, pending}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_segment_scanner.md
Name: seven_segment_scanner

Overview:
Parametrised, time-multiplexed driver for an N-digit common-segment seven-segment display. It holds a hex value with double buffering: a load goes to a shadow register, which is committed at a frame boundary so the display never tears. Each cycle the block scans one digit, decodes it as full hex or as decimal-with-error, and supports per-digit blanking, leading-zero suppression and selectable output polarity. It sits between datapath result registers (e.g. the multiplier product) and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8); data width is 4*NUM_DIGITS.
REFRESH_DIV, 50000, clock cycles each digit stays enabled (>=2).
ACTIVE_LOW, 0, 1 inverts both seg and dig_en at the outputs.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
data_in  input  4*NUM_DIGITS  value to display; nibble k drives digit k (digit 0 is least significant).
load  input  1  one-cycle strobe that captures data_in into the shadow register.
blank_mask  input  NUM_DIGITS  bit k=1 forces digit k dark.
lz_en  input  1  leading-zero suppression enable.
dec_mode  input  1  1: nibbles >9 display 'E'; 0: full hex.
seg  output  7  {a,b,c,d,e,f,g}, registered.
dig_en  output  NUM_DIGITS  one-hot digit enable, registered.
pending  output  1  shadow holds data not yet committed.
frame_tick  output  1  one-cycle pulse when the scan wraps to digit 0.

Behaviour:
- Reset values (ACTIVE_LOW=0): div_cnt=0, digit_idx=0, shadow=0, display=0, pending=0, frame_tick=0, seg=7'b0000000, dig_en=0. With ACTIVE_LOW=1, seg and dig_en reset to all-ones (dark).
- Divider: div_cnt counts 0..REFRESH_DIV-1. The cycle where div_cnt==REFRESH_DIV-1 is the advance cycle: div_cnt wraps to 0 and digit_idx increments.
- digit_idx wraps NUM_DIGITS-1 -> 0. That advance cycle is the frame boundary; frame_tick=1 in the following cycle only.
- One frame is NUM_DIGITS*REFRESH_DIV cycles.
- load without a boundary: shadow<=data_in and pending<=1. A repeated load before the boundary overwrites shadow (last load wins).
- At the boundary without load: display<=shadow and pending<=0.
- At the boundary with load in the same cycle: display<=data_in and shadow<=data_in; pending stays 0.
- Digit decode, using nibble = display[4*digit_idx +: 4]:
  - hex table 0..F: 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011, 1110111, 0011111, 1001110, 0111101, 1001111, 1000111.
  - dec_mode=1 and nibble>9: 1001111 ('E').
- A digit is dark (seg=0, its dig_en bit=0) when either condition holds:
  - its blank_mask bit is 1;
  - lz_en=1, the digit index >0, and it and all higher nibbles are 0.
  Digit 0 is never suppressed by lz_en.
- Outputs are registered from the current digit_idx, display, blank_mask, lz_en and dec_mode, giving one cycle of latency. The first valid digit appears the cycle after reset deasserts. blank_mask, lz_en and dec_mode take effect on the next registered update; they are not double buffered.
- ACTIVE_LOW inverts seg and dig_en after all other logic, including the dark state.
- Reset mid-frame: everything returns to reset values, and pending or shadow data is discarded.

Decomposition:
- Package seven_seg_pkg holds:
  - the SEG_* hex constants (16 entries);
  - SEG_ERR = 7'b1001111 and SEG_BLANK = 7'b0000000;
  - a clog2-based width helper for digit_idx and div_cnt.
- One combinational sub-module, seg7_hex_decode: inputs nibble and dec_mode, output 7-bit seg (active-high). The scanner instantiates it once on the muxed nibble.

Test Plan:
Use NUM_DIGITS=4 and REFRESH_DIV=4, so one frame is 16 cycles.
1. Reset held for 3 cycles, then released with lz_en=0 -> seg=0, dig_en=0 during reset. On cycle 1 after release, dig_en=0001 and seg=1111110. dig_en steps 0010, 0100, 1000 every 4 cycles. frame_tick pulses once every 16 cycles.
2. load with data_in=16'h12AF at cycle 6 -> pending=1 and display unchanged until the boundary, then pending=0. In the next frame, digit0 seg=1000111, digit1=1110111, digit2=1101101, digit3=0110000.
3. Same data with dec_mode=1 -> digits 0 and 1 show 1001111; digits 2 and 3 are unchanged. Then load in the exact boundary cycle with 16'h0003 -> committed immediately and pending never rises.
4. lz_en=1 with 16'h0005 -> only dig_en 0001 is ever asserted, with seg=1011011. With 16'h0000, digit0 shows 1111110 and digits 1..3 stay dark. blank_mask=4'b0001 -> dig_en is always 0.
5. ACTIVE_LOW=1 with 16'h0008 -> during reset seg=1111111 and dig_en=1111; while digit0 is scanned, seg=0000000 and dig_en=1110.
6. load 16'hFFFF, then assert reset at cycle 3 before the boundary -> after reset pending=0 and digit0 shows 1111110 (not F).
